// File: rtl/mvm3_requant.sv
// mvm3_requant: FIFO-buffered requantizer for 3-element MVM result vectors.
// Optional ReLU is enabled by defining MVM3_REQUANT_RELU_EN.
module mvm3_requant #(
   parameter int SHIFT = 4,
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] data_in,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  data_out,
   output logic        m_last,
   output logic [15:0] sat_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic signed [15:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic [1:0]         idx;
   logic               push;
   logic               pop;
   logic signed [15:0] head;
   logic signed [15:0] t;
   logic               over;
   logic               under;
   logic               sat;
   logic [7:0]         q;

   assign s_ready  = (occ < FULL);
   assign m_valid  = (occ != '0);
   assign push     = s_valid && s_ready;
   assign pop      = m_valid && m_ready;
   assign head     = mem[rd_ptr];
   assign t        = head >>> SHIFT;
   assign over     = (t > 16'sd127);
   assign under    = (t < -16'sd128);
   assign data_out = q;
   assign m_last   = (idx == 2'd2);

   // Clamp the shifted head into int8 range and flag counted saturation
   always_comb begin
      q   = t[7:0];
      sat = 1'b0;
`ifdef MVM3_REQUANT_RELU_EN
      if (t[15]) begin
         q = 8'h00;
      end else if (over) begin
         q   = 8'h7f;
         sat = 1'b1;
      end
`else
      if (over) begin
         q   = 8'h7f;
         sat = 1'b1;
      end else if (under) begin
         q   = 8'h80;
         sat = 1'b1;
      end
`endif
   end

   // Storage array; writes during reset are dropped
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy; a concurrent push and pop keeps occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
      end
   end

   // Element index within the vector and sticky saturation counter
   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= 2'd0;
         sat_count <= 16'd0;
      end else if (pop) begin
         idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         if (sat && sat_count != 16'hffff) begin
            sat_count <= sat_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mvm3_requant.sv
// tb_mvm3_requant: directed vector table plus backpressure, random
// handshake and mid-operation reset sequences for mvm3_requant.
module tb_mvm3_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] data_in;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  data_out;
   logic        m_last;
   logic [15:0] sat_count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] din;
      logic [7:0]  dout;
      logic [7:0]  dout_relu;
      logic        last;
      logic [15:0] sat;
      logic [15:0] sat_relu;
   } vec_t;

   vec_t tbl [12];

   mvm3_requant #(.SHIFT(4), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .data_in   (data_in),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .data_out  (data_out),
      .m_last    (m_last),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Push one value into an empty FIFO, check head, then pop it
   task automatic push_pop(input logic [15:0] din, input logic [7:0] dout,
                           input logic last, input logic [15:0] sat,
                           input string nm);
      s_valid = 1'b1;
      data_in = din;
      m_ready = 1'b0;
      @(posedge clk);
      #1 s_valid = 1'b0;
      data_in = 'x;
      chk({nm, ".valid"}, 32'(m_valid), 32'd1);
      chk({nm, ".data"}, 32'(data_out), 32'(dout));
      chk({nm, ".last"}, 32'(m_last), 32'(last));
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
      chk({nm, ".sat"}, 32'(sat_count), 32'(sat));
      chk({nm, ".empty"}, 32'(m_valid), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{16'h0120, 8'h12, 8'h12, 1'b0, 16'd0, 16'd0};
      tbl[1]  = '{16'h0030, 8'h03, 8'h03, 1'b0, 16'd0, 16'd0};
      tbl[2]  = '{16'hfff0, 8'hff, 8'h00, 1'b1, 16'd0, 16'd0};
      tbl[3]  = '{16'h7fff, 8'h7f, 8'h7f, 1'b0, 16'd1, 16'd1};
      tbl[4]  = '{16'h8000, 8'h80, 8'h00, 1'b0, 16'd2, 16'd1};
      tbl[5]  = '{16'hf800, 8'h80, 8'h00, 1'b1, 16'd2, 16'd1};
      tbl[6]  = '{16'h07f0, 8'h7f, 8'h7f, 1'b0, 16'd2, 16'd1};
      tbl[7]  = '{16'h0800, 8'h7f, 8'h7f, 1'b0, 16'd3, 16'd2};
      tbl[8]  = '{16'hf7f0, 8'h80, 8'h00, 1'b1, 16'd4, 16'd2};
      tbl[9]  = '{16'h000f, 8'h00, 8'h00, 1'b0, 16'd4, 16'd2};
      tbl[10] = '{16'hffff, 8'hff, 8'h00, 1'b0, 16'd4, 16'd2};
      tbl[11] = '{16'h0000, 8'h00, 8'h00, 1'b1, 16'd4, 16'd2};

      reset   = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      data_in = 'x;
      do_reset();

      chk("rst.s_ready", 32'(s_ready), 32'd1);
      chk("rst.m_valid", 32'(m_valid), 32'd0);
      chk("rst.m_last", 32'(m_last), 32'd0);
      chk("rst.sat", 32'(sat_count), 32'd0);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
`ifdef MVM3_REQUANT_RELU_EN
         push_pop(tbl[i].din, tbl[i].dout_relu, tbl[i].last,
                  tbl[i].sat_relu, $sformatf("vec%0d", i));
`else
         push_pop(tbl[i].din, tbl[i].dout, tbl[i].last,
                  tbl[i].sat, $sformatf("vec%0d", i));
`endif
      end

      // Backpressure: fill 8, ninth waits until one pop frees a slot
      do_reset();
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         data_in = 16'(i << 4);
         chk($sformatf("bp.rdy%0d", i), 32'(s_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      chk("bp.full", 32'(s_ready), 32'd0);
      data_in = 16'(8 << 4);
      @(posedge clk);
      #1 chk("bp.pend", 32'(s_ready), 32'd0);
      chk("bp.head", 32'(data_out), 32'd0);
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
      chk("bp.freed", 32'(s_ready), 32'd1);
      chk("bp.head1", 32'(data_out), 32'd1);
      @(posedge clk);
      #1 s_valid = 1'b0;
      data_in = 'x;
      chk("bp.refull", 32'(s_ready), 32'd0);
      m_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         chk($sformatf("bp.d%0d", i), 32'(data_out), 32'(i));
         chk($sformatf("bp.l%0d", i), 32'(m_last), 32'(i % 3 == 2));
         @(posedge clk);
         #1;
      end
      m_ready = 1'b0;
      chk("bp.drained", 32'(m_valid), 32'd0);

      // Random handshakes over 15 values
      do_reset();
      begin
         int sent = 0;
         int recv = 0;
         int cyc  = 0;
         while (recv < 15 && cyc < 2000) begin
            s_valid = (sent < 15) && ($urandom_range(0, 1) == 1);
            data_in = s_valid ? 16'(sent << 4) : 'x;
            m_ready = ($urandom_range(0, 2) == 0);
            if (m_valid && m_ready) begin
               chk($sformatf("rnd.d%0d", recv), 32'(data_out), 32'(recv));
               chk($sformatf("rnd.l%0d", recv), 32'(m_last),
                   32'(recv % 3 == 2));
               recv++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1 cyc++;
         end
         s_valid = 1'b0;
         m_ready = 1'b0;
         chk("rnd.count", 32'(recv), 32'd15);
         chk("rnd.sat", 32'(sat_count), 32'd0);
         chk("rnd.empty", 32'(m_valid), 32'd0);
      end

      // Reset with 4 buffered entries and index at 1
      do_reset();
      push_pop(16'h7fff, 8'h7f, 1'b0, 16'd1, "mr.pre");
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         data_in = 16'h0100;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      chk("mr.fill", 32'(m_valid), 32'd1);
      reset   = 1'b1;
      s_valid = 1'b1;
      data_in = 16'h0550;
      m_ready = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      chk("mr.m_valid", 32'(m_valid), 32'd0);
      chk("mr.s_ready", 32'(s_ready), 32'd1);
      chk("mr.sat", 32'(sat_count), 32'd0);
      chk("mr.last", 32'(m_last), 32'd0);
      @(posedge clk);
      #1 chk("mr.nostale", 32'(m_valid), 32'd0);
      push_pop(16'h0120, 8'h12, 1'b0, 16'd0, "mr.v0");
      push_pop(16'h0030, 8'h03, 1'b0, 16'd0, "mr.v1");
      push_pop(16'h0040, 8'h04, 1'b1, 16'd0, "mr.v2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mvm3_requant.md
MVM3_REQUANT -- requirements
Module: mvm3_requant

Interface
REQ-001 Parameter SHIFT, default 4, arithmetic right-shift amount applied to each result, legal range 0..15.
REQ-002 Parameter DEPTH, default 8, FIFO entries, power of two, minimum 4.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port s_valid  input  1  upstream result valid.
REQ-006 Port s_ready  output  1  block can accept a result.
REQ-007 Port data_in  input  16  signed two's-complement y value from the matrix-vector multiplier.
REQ-008 Port m_valid  output  1  requantized value available.
REQ-009 Port m_ready  input  1  downstream accepts value.
REQ-010 Port data_out  output  8  signed requantized value.
REQ-011 Port m_last  output  1  marks third (final) element of each 3-element result vector.
REQ-012 Port sat_count  output  16  number of clamped outputs since reset.

Function
REQ-013 Input transfer SHALL occur only on a rising edge with s_valid && s_ready; data_in SHALL be ignored, even if X, when s_valid is low.
REQ-014 Output transfer SHALL occur only on a rising edge with m_valid && m_ready.
REQ-015 Accepted values SHALL be stored in order in a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-016 s_ready SHALL equal (occupancy < DEPTH); full with a simultaneous read SHALL NOT accept (no pass-through).
REQ-017 m_valid SHALL equal (occupancy > 0); empty with a simultaneous write SHALL NOT output that value in the same cycle.
REQ-018 Latency: a value accepted at edge N SHALL be presentable (m_valid=1) in the cycle following edge N if the FIFO was empty.
REQ-019 Simultaneous accept and output SHALL leave occupancy unchanged and advance both pointers.
REQ-020 data_out SHALL be computed from the FIFO head: t = head >>> SHIFT (sign-preserving), then clamp to [-128, 127].
REQ-021 m_valid, data_out and m_last SHALL hold stable while m_valid && !m_ready.
REQ-022 A 2-bit element index SHALL count 0,1,2,0,... advancing on each output transfer; m_last SHALL be 1 exactly when index == 2.
REQ-023 sat_count SHALL increment on each output transfer whose t was outside [-128, 127], and SHALL stick at 0xFFFF.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no loss or duplication of entries.

Reset
REQ-025 While reset is high at an edge: occupancy, both pointers, element index and sat_count SHALL clear to 0.
REQ-026 During and after reset: s_ready=1, m_valid=0, m_last=0, sat_count=0; data_out is don't-care while m_valid=0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; no stale value SHALL appear after reset deasserts.
REQ-028 A transfer presented in the same cycle as reset SHALL be dropped.

Configuration
REQ-029 Macro MVM3_REQUANT_RELU_EN SHALL control ReLU.
- Defined: any negative t SHALL produce data_out = 0x00; ReLU zeroing SHALL NOT count as saturation; positive clamping still counts.
- Undefined: negative t SHALL clamp to -128 and count as saturation when t < -128.

Verification
REQ-030 SHIFT=4, inputs 0x0120, 0x0030, 0xFFF0 with m_ready=1 -> outputs 0x12, 0x03, 0xFF (0x00 with RELU_EN); m_last only on the third; sat_count=0.
REQ-031 Input 0x7FFF -> 0x7F, sat_count=1. Input 0x8000 -> 0x80 with sat_count=2 without RELU_EN; 0x00 with sat_count=1 with RELU_EN.
REQ-032 m_ready=0, push 9 values -> s_ready drops after the 8th accept and the 9th stays pending; then one m_ready pulse -> exactly one pop, 9th accepted next edge, order preserved.
REQ-033 Random s_valid/m_ready over 5 vectors (15 values) -> 15 outputs in order, m_last every 3rd, pointers wrap with no loss.
REQ-034 Reset asserted with 4 values buffered and index=1 -> next cycle m_valid=0, s_ready=1, sat_count=0; next vector restarts at index 0.
